// File: rtl/approx_wallace_accumulate_stage.sv
// approx_wallace_accumulate_stage
// Closes the approximate Wallace-tree MAC path. The final two reduced rows are
// captured (P1) and then added exactly and folded into a running frame sum (P2).
// After ACC_LEN products the frame sum is offered on a valid/ready handshake.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous frame flush (discards partial or pending frame)
//   in_valid_i   reduced rows present
//   in_ready_o   stage accepts rows this cycle
//   sum_vec_i    reduced sum row, bit i has weight 2^i
//   carry_vec_i  reduced carry row, pre-aligned, bit i has weight 2^i
//   out_valid_o  frame sum available
//   out_ready_i  consumer takes frame sum
//   acc_out_o    accumulator register (meaningful while out_valid_o=1)
//   overflow_o   sticky per frame: the sum exceeded 2^ACC_WIDTH-1
module approx_wallace_accumulate_stage #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned ACC_LEN   = 16,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [15:0]          sum_vec_i,
  input  logic [15:0]          carry_vec_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] acc_out_o,
  output logic                 overflow_o
);

  localparam int unsigned          CntW   = $clog2(ACC_LEN + 1);
  localparam logic [CntW-1:0]      LenCnt = CntW'(ACC_LEN);
  localparam logic [ACC_WIDTH-1:0] AccMax = '1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   p1_valid_q, p1_valid_d;
  logic [15:0]            p1_sum_q, p1_sum_d;
  logic [15:0]            p1_carry_q, p1_carry_d;
  logic [CntW-1:0]        taken_q, taken_d;
  logic [CntW-1:0]        added_q, added_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;

  logic                   accept;
  logic [16:0]            product;
  logic [ACC_WIDTH:0]     sum_full;

  // Terms beyond ACC_LEN are held off (not dropped) until the frame is handed over.
  assign in_ready_o = rst_ni & ~clear_i & (state_q != StDone) & (taken_q < LenCnt);
  assign accept     = in_valid_i & in_ready_o;

  assign product  = {1'b0, p1_sum_q} + {1'b0, p1_carry_q};
  assign sum_full = {1'b0, acc_q} + {{(ACC_WIDTH - 16){1'b0}}, product};

  always_comb begin
    state_d    = state_q;
    p1_valid_d = 1'b0;
    p1_sum_d   = p1_sum_q;
    p1_carry_d = p1_carry_q;
    taken_d    = taken_q;
    added_d    = added_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;

    if (clear_i) begin
      state_d = StIdle;
      taken_d = '0;
      added_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (accept) begin
        p1_valid_d = 1'b1;
        p1_sum_d   = sum_vec_i;
        p1_carry_d = carry_vec_i;
        taken_d    = taken_q + CntW'(1);
      end

      if (p1_valid_q) begin
        added_d = added_q + CntW'(1);
        if (sum_full[ACC_WIDTH]) begin
          ovf_d = 1'b1;
          // Once clamped at all-ones, any further non-zero add carries out again,
          // so the clamp persists for the rest of the frame.
          acc_d = SATURATE ? AccMax : sum_full[ACC_WIDTH-1:0];
        end else begin
          acc_d = sum_full[ACC_WIDTH-1:0];
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) state_d = StAccum;
        end
        // Waiting for the registered count adds the second edge of output latency.
        StAccum: begin
          if (added_q == LenCnt) state_d = StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
            taken_d = '0;
            added_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      p1_valid_q <= 1'b0;
      p1_sum_q   <= '0;
      p1_carry_q <= '0;
      taken_q    <= '0;
      added_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_valid_q <= p1_valid_d;
      p1_sum_q   <= p1_sum_d;
      p1_carry_q <= p1_carry_d;
      taken_q    <= taken_d;
      added_q    <= added_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid_o = (state_q == StDone);
  assign acc_out_o   = acc_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_approx_wallace_accumulate_stage.sv
// Directed and randomised bench for approx_wallace_accumulate_stage.
// Three ACC_LEN=4 instances share stimulus (24-bit saturating, 17-bit saturating,
// 17-bit wrapping); ACC_LEN=16 and ACC_LEN=1 instances take the random traffic.
module tb_approx_wallace_accumulate_stage;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus for the ACC_LEN=4 instances
  logic        clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] sum_v = '0, carry_v = '0;

  logic        ir_a, ov_a, of_a;  logic [23:0] acc_a;
  logic        ir_s, ov_s, of_s;  logic [16:0] acc_s;
  logic        ir_w, ov_w, of_w;  logic [16:0] acc_w;

  // random-phase stimulus
  logic        vld_r = 1'b0, vld_o = 1'b0, ordy_r = 1'b0, ordy_o = 1'b0;
  logic [15:0] rs = '0, rc = '0;
  logic        ir_r, ov_r, of_r;  logic [23:0] acc_r;
  logic        ir_o, ov_o, of_o;  logic [23:0] acc_o;

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] sb[$];

  approx_wallace_accumulate_stage #(.ACC_WIDTH(24), .ACC_LEN(4), .SATURATE(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(ir_a),
    .sum_vec_i(sum_v), .carry_vec_i(carry_v), .out_valid_o(ov_a), .out_ready_i(out_ready),
    .acc_out_o(acc_a), .overflow_o(of_a));

  approx_wallace_accumulate_stage #(.ACC_WIDTH(17), .ACC_LEN(4), .SATURATE(1'b1)) u_s (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(ir_s),
    .sum_vec_i(sum_v), .carry_vec_i(carry_v), .out_valid_o(ov_s), .out_ready_i(out_ready),
    .acc_out_o(acc_s), .overflow_o(of_s));

  approx_wallace_accumulate_stage #(.ACC_WIDTH(17), .ACC_LEN(4), .SATURATE(1'b0)) u_w (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(ir_w),
    .sum_vec_i(sum_v), .carry_vec_i(carry_v), .out_valid_o(ov_w), .out_ready_i(out_ready),
    .acc_out_o(acc_w), .overflow_o(of_w));

  approx_wallace_accumulate_stage #(.ACC_WIDTH(24), .ACC_LEN(16), .SATURATE(1'b1)) u_r (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(1'b0), .in_valid_i(vld_r), .in_ready_o(ir_r),
    .sum_vec_i(rs), .carry_vec_i(rc), .out_valid_o(ov_r), .out_ready_i(ordy_r),
    .acc_out_o(acc_r), .overflow_o(of_r));

  approx_wallace_accumulate_stage #(.ACC_WIDTH(24), .ACC_LEN(1), .SATURATE(1'b1)) u_o (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(1'b0), .in_valid_i(vld_o), .in_ready_o(ir_o),
    .sum_vec_i(rs), .carry_vec_i(rc), .out_valid_o(ov_o), .out_ready_i(ordy_o),
    .acc_out_o(acc_o), .overflow_o(of_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer n terms, holding data until each is accepted; returns cycles used.
  task automatic send_terms(input int n, input logic [15:0] s, input logic [15:0] c,
                            output int cycles);
    int cnt = 0;
    cycles = 0;
    in_valid = 1'b1; sum_v = s; carry_v = c;
    while (cnt < n && cycles < 50) begin
      @(negedge clk);
      if (ir_a) cnt++;
      cycles++;
      step();
    end
    in_valid = 1'b0;
    chk("accept_count", cnt, n);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!ov_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, ov_a, 1);
    if (sb.size() > 0) chk(tag, acc_a, sb.pop_front());
    else chk({tag, "_sb"}, sb.size(), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", ov_a, 0);
  endtask

  task automatic run_random(input bit sel, input int frames, input int len);
    int pushed = 0, done = 0, taken = 0, cyc = 0;
    logic [31:0] gold = 0;
    bit pend = 0, vld = 0, ordy = 0;
    logic ir, ov, of;
    logic [23:0] acc;
    while (done < frames && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      ir  = sel ? ir_o : ir_r;
      ov  = sel ? ov_o : ov_r;
      of  = sel ? of_o : of_r;
      acc = sel ? acc_o : acc_r;
      if (ov && ordy) begin
        if (sb.size() > 0) chk(sel ? "rand_len1_sum" : "rand_len16_sum", acc, sb.pop_front());
        else chk("rand_spurious_out", sb.size(), 1);
        chk("rand_ovf", of, 0);
        done++;
      end
      if (vld && ir) begin
        gold += 32'(rs) + 32'(rc);
        taken++;
        pend = 0;
        if (taken == len) begin
          sb.push_back(gold);
          gold = 0; taken = 0; pushed++;
        end
      end
      step();
      if (!pend) begin
        if (pushed < frames && $urandom_range(0, 3) != 0) begin
          vld = 1; rs = 16'($urandom); rc = 16'($urandom); pend = 1;
        end else vld = 0;
      end
      ordy = ($urandom_range(0, 2) != 0);
      vld_r = sel ? 1'b0 : vld;  vld_o = sel ? vld : 1'b0;
      ordy_r = sel ? 1'b0 : ordy; ordy_o = sel ? ordy : 1'b0;
    end
    vld_r = 1'b0; vld_o = 1'b0; ordy_r = 1'b0; ordy_o = 1'b0;
    chk(sel ? "rand_len1_frames" : "rand_len16_frames", done, frames);
    chk("rand_sb_drained", sb.size(), 0);
  endtask

  initial begin
    int cyc;
    // reset
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_in_ready", ir_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_ovf", of_a, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    step();
    chk("idle_in_ready", ir_a, 1);

    // exact accumulate: 4 x 256, two-edge latency
    sb.push_back(32'h400);
    send_terms(4, 16'h00FF, 16'h0001, cyc);
    chk("t1_back_to_back", cyc, 4);
    chk("t1_lat_e0", ov_a, 0);
    step();
    chk("t1_lat_e1", ov_a, 0);
    step();
    chk("t1_lat_e2", ov_a, 1);
    wait_done("t1_sum");
    chk("t1_ovf", of_a, 0);

    // backpressure, next frame's term waiting
    in_valid = 1'b1; sum_v = 16'h0002; carry_v = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", ir_a, 0);
      chk("bp_acc_stable", acc_a, 32'h400);
      chk("bp_valid", ov_a, 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", ir_a, 0);
    step();
    out_ready = 1'b0;
    chk("hs_valid_low", ov_a, 0);
    sb.push_back(32'd12);
    send_terms(4, 16'h0002, 16'h0001, cyc);
    wait_done("bp_next_sum");
    handshake();

    // overflow: 4 x 65536
    sb.push_back(32'h40000);
    send_terms(4, 16'hFFFF, 16'h0001, cyc);
    wait_done("ovf_w24_sum");
    chk("ovf_w24_flag", of_a, 0);
    chk("ovf_sat_valid", ov_s, 1);
    chk("ovf_sat_acc", acc_s, 32'h1FFFF);
    chk("ovf_sat_flag", of_s, 1);
    chk("ovf_wrap_acc", acc_w, 32'h0);
    chk("ovf_wrap_flag", of_w, 1);
    handshake();
    chk("ovf_sat_cleared", of_s, 0);
    chk("ovf_wrap_cleared", of_w, 0);

    // mid-frame clear with a term offered
    send_terms(2, 16'h00FF, 16'h0001, cyc);
    in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", ir_a, 0);
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", ov_a, 0);
    chk("clr_acc", acc_a, 0);
    sb.push_back(32'd12);
    send_terms(4, 16'h0002, 16'h0001, cyc);
    wait_done("clr_next_sum");
    handshake();

    // async reset between edges, mid-frame
    send_terms(3, 16'h00FF, 16'h0001, cyc);
    in_valid = 1'b1;
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_in_ready", ir_a, 0);
    chk("arst_valid", ov_a, 0);
    chk("arst_acc", acc_a, 0);
    chk("arst_ovf", of_a, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    sb.push_back(32'd12);
    send_terms(4, 16'h0002, 16'h0001, cyc);
    wait_done("arst_next_sum");
    handshake();

    // random bubbles and stalls
    run_random(1'b0, 200, 16);
    run_random(1'b1, 60, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
